// File: rtl/rr_lock_arb_if.sv
// Request/grant bundle between the requesters, the consumer and rr_lock_arb.
// The arbiter uses the master view; the sources/consumer side uses the slave view.
interface rr_lock_arb_if #(
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic          lock;
    logic          accept;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_idx;
    logic          locked;

    modport master (
        input  req, lock, accept,
        output gnt, gnt_valid, gnt_idx, locked
    );

    modport slave (
        output req, lock, accept,
        input  gnt, gnt_valid, gnt_idx, locked
    );
endinterface

// File: rtl/rr_lock_arb.sv
// Round-robin arbiter with a transfer lock: zero-latency one-hot grant,
// pointer advances past each winner on an unlocked accepted beat.
module rr_lock_arb #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           resetn,
    rr_lock_arb_if.master  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          lk_q, lk_d;

    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;
    logic [IW-1:0] scan_idx;
    logic          found;
    int            scan_pos;

    // While locked only the owner may be granted; otherwise the first
    // requester found scanning upward from ptr wins.
    always_comb begin
        gnt      = '0;
        found    = 1'b0;
        scan_pos = 0;
        scan_idx = '0;
        if (lk_q) begin
            if (bus.req[owner_q]) gnt[owner_q] = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                scan_pos = int'(ptr_q) + k;
                if (scan_pos >= N) scan_pos = scan_pos - N;
                scan_idx = IW'(scan_pos);
                if (!found && bus.req[scan_idx]) begin
                    gnt[scan_idx] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) gnt_idx = IW'(i);
        end
    end

    assign gnt_valid = |gnt;

    always_comb begin
        ptr_d   = ptr_q;
        owner_d = owner_q;
        lk_d    = lk_q;
        if (bus.accept && gnt_valid) begin
            if (bus.lock) begin
                lk_d    = 1'b1;
                owner_d = gnt_idx;
            end else begin
                lk_d  = 1'b0;
                ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_q   <= '0;
            owner_q <= '0;
            lk_q    <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            lk_q    <= lk_d;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.gnt_valid = gnt_valid;
    assign bus.gnt_idx   = gnt_idx;
    assign bus.locked    = lk_q;

    a_ptr_range: assert property (@(posedge clk) disable iff (!resetn)
        (int'(ptr_q) < N) && (int'(owner_q) < N));

endmodule

// File: tb/tb_rr_lock_arb.sv
// Directed scenarios with literal expectations, then random traffic checked
// every cycle against a behavioural round-robin/lock model.
module tb_rr_lock_arb;
    localparam int N = 4;

    logic clk = 1'b0;
    logic resetn;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    rr_lock_arb_if #(.N(N)) bus ();

    rr_lock_arb #(.N(N)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master)
    );

    // Model state: priority start, lock flag, lock owner, plus "state known".
    int m_ptr = 0;
    int m_own = 0;
    bit m_lk  = 1'b0;
    bit m_ok  = 1'b0;
    int m_gi;

    function automatic int model_winner(logic [N-1:0] r, int p, bit l, int o);
        if (l) return (((r >> o) & 4'd1) != 4'd0) ? o : -1;
        for (int k = 0; k < N; k++) begin
            if (((r >> ((p + k) % N)) & 4'd1) != 4'd0) return (p + k) % N;
        end
        return -1;
    endfunction

    always_comb m_gi = model_winner(bus.req, m_ptr, m_lk, m_own);

    always @(posedge clk) begin
        if (!resetn) begin
            m_ptr <= 0;
            m_own <= 0;
            m_lk  <= 1'b0;
            m_ok  <= 1'b1;
        end else if (bus.accept && m_gi >= 0) begin
            if (bus.lock) begin
                m_lk  <= 1'b1;
                m_own <= m_gi;
            end else begin
                m_lk  <= 1'b0;
                m_ptr <= (m_gi + 1) % N;
            end
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic [1:0]   ei;
        if (m_ok) begin
            eg = (m_gi >= 0) ? (4'b0001 << m_gi) : 4'b0000;
            ei = (m_gi >= 0) ? 2'(m_gi) : 2'd0;
            tests++;
            if (bus.gnt !== eg || bus.gnt_idx !== ei || bus.gnt_valid !== (m_gi >= 0) ||
                bus.locked !== m_lk) begin
                fails++;
                $display("FAIL model t=%0t gnt got %b exp %b, idx got %0d exp %0d, vld got %b exp %b, locked got %b exp %b",
                         $time, bus.gnt, eg, bus.gnt_idx, ei, bus.gnt_valid, (m_gi >= 0), bus.locked, m_lk);
            end
        end
    end

    // Hand-computed expectation for one cycle, then advance past the next edge.
    task automatic cyc(input string nm, input logic [N-1:0] g, input int i, input bit l);
        @(negedge clk);
        tests++;
        if (bus.gnt !== g || bus.gnt_idx !== 2'(i) || bus.gnt_valid !== (|g) || bus.locked !== l) begin
            fails++;
            $display("FAIL %s gnt got %b exp %b, idx got %0d exp %0d, vld got %b exp %b, locked got %b exp %b",
                     nm, bus.gnt, g, bus.gnt_idx, i, bus.gnt_valid, (|g), bus.locked, l);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] r, input bit l, input bit a);
        bus.req    = r;
        bus.lock   = l;
        bus.accept = a;
    endtask

    initial begin
        resetn = 1'b0;
        drive(4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cyc("reset", 4'b0000, 0, 1'b0);

        drive(4'b1111, 1'b0, 1'b0);
        repeat (3) cyc("hold", 4'b0001, 0, 1'b0);

        drive(4'b1111, 1'b0, 1'b1);
        cyc("rr0", 4'b0001, 0, 1'b0);
        cyc("rr1", 4'b0010, 1, 1'b0);
        cyc("rr2", 4'b0100, 2, 1'b0);
        cyc("rr3", 4'b1000, 3, 1'b0);
        cyc("rr_wrap", 4'b0001, 0, 1'b0);

        drive(4'b1001, 1'b0, 1'b1);
        cyc("skip_a", 4'b1000, 3, 1'b0);
        cyc("skip_b", 4'b0001, 0, 1'b0);
        drive(4'b0100, 1'b0, 1'b0);
        cyc("alone", 4'b0100, 2, 1'b0);

        drive(4'b0110, 1'b1, 1'b1);
        cyc("lock_b1", 4'b0010, 1, 1'b0);
        cyc("lock_b2", 4'b0010, 1, 1'b1);
        drive(4'b0100, 1'b1, 1'b0);
        cyc("lock_drop", 4'b0000, 0, 1'b1);
        drive(4'b0110, 1'b1, 1'b1);
        cyc("lock_b3", 4'b0010, 1, 1'b1);
        drive(4'b0110, 1'b0, 1'b1);
        cyc("lock_b4", 4'b0010, 1, 1'b1);
        drive(4'b0110, 1'b0, 1'b0);
        cyc("lock_end", 4'b0100, 2, 1'b0);

        drive(4'b0000, 1'b0, 1'b1);
        cyc("acc_nognt", 4'b0000, 0, 1'b0);
        drive(4'b1010, 1'b0, 1'b0);
        cyc("noacc_a", 4'b1000, 3, 1'b0);
        cyc("noacc_b", 4'b1000, 3, 1'b0);

        drive(4'b0100, 1'b1, 1'b1);
        cyc("lk2_set", 4'b0100, 2, 1'b0);
        drive(4'b1111, 1'b0, 1'b0);
        cyc("lk2_held", 4'b0100, 2, 1'b1);
        resetn = 1'b0;
        cyc("lk2_rst", 4'b0100, 2, 1'b1);
        resetn = 1'b1;
        cyc("post_rst", 4'b0001, 0, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            resetn = ($urandom_range(0, 199) != 0);
            drive(N'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
            @(posedge clk);
            #1;
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
